prefetch_ar_arbiter: RTL and testbench

- Shares the single AXI read-address (AR) master port between demand misses and prefetcher-generated requests.
- Demand misses come from the slave side; prefetch requests come from the prefetcher controller's master port.
- Tracks in-flight reads and exports the outstanding count and limit that gate prefetch issue.
- Steers R-channel handshakes back to the owning requester using a source bit carried in the AXI ID.

---
 rtl/prefetch_pkg.sv | 20 ++
 rtl/outstanding_counter.sv | 44 ++++
 rtl/prefetch_ar_arbiter.sv | 145 ++++++++++++++
 tb/tb_prefetch_ar_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/prefetch_pkg.sv
// Shared types for the prefetch AR arbiter: request source, arbiter state and
// the outstanding-count width helper.
package prefetch_pkg;

  typedef enum logic {
    SRC_DEM = 1'b0,
    SRC_PF  = 1'b1
  } ar_src_e;

  typedef enum logic [1:0] {
    IDLE,
    HOLD_DEM,
    HOLD_PF
  } arb_state_e;

  function automatic int unsigned out_cnt_width(int unsigned log_reqs);
    return log_reqs + 1;
  endfunction

endpackage

// File: rtl/outstanding_counter.sv
// Up/down count of in-flight reads; saturates at 2^LOG_OUTSTAND_REQS and never
// wraps below zero.
module outstanding_counter
  import prefetch_pkg::*;
#(
  parameter int unsigned LOG_OUTSTAND_REQS = 6
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       inc_i,
  input  logic                       dec_i,
  output logic [LOG_OUTSTAND_REQS:0] cnt_o
);

  localparam int unsigned CntW = out_cnt_width(LOG_OUTSTAND_REQS);
  localparam logic [CntW-1:0] CntMax = {1'b1, {LOG_OUTSTAND_REQS{1'b0}}};

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

  // A last beat with nothing in flight means the R channel lost track of an AR.
  underflow_a : assert property (@(posedge clk_i) disable iff (rst_i)
    !(dec_i && !inc_i && cnt_q == '0))
    else $error("outstanding_counter: read completion with zero reads in flight");

endmodule

// File: rtl/prefetch_ar_arbiter.sv
// Shares one AXI AR port between demand misses and prefetches, tracks in-flight
// reads and steers R handshakes back to the owner via the ID MSB.
module prefetch_ar_arbiter
  import prefetch_pkg::*;
#(
  parameter int unsigned ADDR_BITS         = 64,
  parameter int unsigned ID_BITS           = 4,
  parameter int unsigned LOG_OUTSTAND_REQS = 6,
  parameter int unsigned PF_STARVE_LIMIT   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flushN,
  input  logic                       demValid,
  input  logic [ADDR_BITS-1:0]       demAddr,
  input  logic [ID_BITS-1:0]         demId,
  output logic                       demReady,
  input  logic                       pfValid,
  input  logic [ADDR_BITS-1:0]       pfAddr,
  output logic                       pfReady,
  input  logic [LOG_OUTSTAND_REQS:0] outstandingReqLimit,
  output logic [LOG_OUTSTAND_REQS:0] outstandingReqCnt,
  output logic                       pfAllowed,
  output logic                       arValid,
  output logic [ADDR_BITS-1:0]       arAddr,
  output logic [ID_BITS:0]           arId,
  input  logic                       arReady,
  input  logic                       rValid,
  input  logic [ID_BITS:0]           rId,
  input  logic                       rLast,
  output logic                       rReady,
  output logic                       demRValid,
  input  logic                       demRReady,
  output logic                       pfRValid,
  input  logic                       pfRReady
);

  localparam logic [LOG_OUTSTAND_REQS:0] CntMax = {1'b1, {LOG_OUTSTAND_REQS{1'b0}}};
  localparam int unsigned StarveW = $clog2(PF_STARVE_LIMIT + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(PF_STARVE_LIMIT);

  arb_state_e           state_q, state_d;
  logic [ADDR_BITS-1:0] ar_addr_q, ar_addr_d;
  logic [ID_BITS:0]     ar_id_q, ar_id_d;
  logic [StarveW-1:0]   starve_q, starve_d;

  logic cnt_room, pf_elig, dem_elig;
  logic grant_dem, grant_pf;
  logic ar_hs, r_done;

  assign pfAllowed = outstandingReqCnt < outstandingReqLimit;
  assign cnt_room  = outstandingReqCnt < CntMax;
  assign pf_elig   = pfValid && pfAllowed && flushN && cnt_room;
  assign dem_elig  = demValid && cnt_room;

  always_comb begin
    state_d   = state_q;
    ar_addr_d = ar_addr_q;
    ar_id_d   = ar_id_q;
    starve_d  = starve_q;
    grant_dem = 1'b0;
    grant_pf  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (starve_q == StarveMax && pf_elig) begin
          grant_pf = 1'b1;
        end else if (dem_elig) begin
          grant_dem = 1'b1;
          if (pf_elig && starve_q != StarveMax) begin
            starve_d = starve_q + 1'b1;
          end
        end else if (pf_elig) begin
          grant_pf = 1'b1;
        end
        if (grant_pf) begin
          state_d   = HOLD_PF;
          ar_addr_d = pfAddr;
          ar_id_d   = {SRC_PF, {ID_BITS{1'b0}}};
          starve_d  = '0;
        end else if (grant_dem) begin
          state_d   = HOLD_DEM;
          ar_addr_d = demAddr;
          ar_id_d   = {SRC_DEM, demId};
        end
      end
      HOLD_DEM, HOLD_PF: begin
        if (arReady) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!flushN) begin
      starve_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ar_addr_q <= '0;
      ar_id_q   <= '0;
      starve_q  <= '0;
    end else begin
      state_q   <= state_d;
      ar_addr_q <= ar_addr_d;
      ar_id_q   <= ar_id_d;
      starve_q  <= starve_d;
    end
  end

  // Acceptance is combinational, so mask it while reset discards the grant.
  assign demReady = grant_dem && !reset;
  assign pfReady  = grant_pf && !reset;

  assign arValid = (state_q != IDLE);
  assign arAddr  = ar_addr_q;
  assign arId    = ar_id_q;

  always_comb begin
    demRValid = 1'b0;
    pfRValid  = 1'b0;
    rReady    = demRReady;
    if (rId[ID_BITS] == SRC_PF) begin
      pfRValid = rValid;
      rReady   = pfRReady;
    end else begin
      demRValid = rValid;
    end
  end

  assign ar_hs  = arValid && arReady;
  assign r_done = rValid && rReady && rLast;

  outstanding_counter #(
    .LOG_OUTSTAND_REQS(LOG_OUTSTAND_REQS)
  ) u_outstanding_counter (
    .clk_i(clk),
    .rst_i(reset),
    .inc_i(ar_hs),
    .dec_i(r_done),
    .cnt_o(outstandingReqCnt)
  );

endmodule

// File: tb/tb_prefetch_ar_arbiter.sv
// Directed bench for prefetch_ar_arbiter with hand-computed expectations.
module tb_prefetch_ar_arbiter;

  logic        clk = 1'b0;
  logic        reset, flushN;
  logic        demValid, demReady, pfValid, pfReady;
  logic [63:0] demAddr, pfAddr, arAddr;
  logic [3:0]  demId;
  logic [6:0]  outstandingReqLimit, outstandingReqCnt;
  logic        pfAllowed, arValid, arReady;
  logic [4:0]  arId, rId;
  logic        rValid, rLast, rReady, demRValid, demRReady, pfRValid, pfRReady;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prefetch_ar_arbiter dut (
    .clk(clk), .reset(reset), .flushN(flushN),
    .demValid(demValid), .demAddr(demAddr), .demId(demId), .demReady(demReady),
    .pfValid(pfValid), .pfAddr(pfAddr), .pfReady(pfReady),
    .outstandingReqLimit(outstandingReqLimit), .outstandingReqCnt(outstandingReqCnt),
    .pfAllowed(pfAllowed),
    .arValid(arValid), .arAddr(arAddr), .arId(arId), .arReady(arReady),
    .rValid(rValid), .rId(rId), .rLast(rLast), .rReady(rReady),
    .demRValid(demRValid), .demRReady(demRReady),
    .pfRValid(pfRValid), .pfRReady(pfRReady)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge, then let combinational outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    demValid = 1'b0; pfValid = 1'b0; rValid = 1'b0; rLast = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flushN = 1'b1;
    demValid = 1'b0; demAddr = '0; demId = '0;
    pfValid = 1'b0; pfAddr = '0; outstandingReqLimit = 7'd20;
    arReady = 1'b0; rValid = 1'b0; rId = '0; rLast = 1'b0;
    demRReady = 1'b0; pfRReady = 1'b0;
    tick(); tick();
    reset = 1'b0;
    settle();
    chk("rst_arvalid", arValid, 0);
    chk("rst_demready", demReady, 0);
    chk("rst_pfready", pfReady, 0);
    chk("rst_araddr", arAddr, 0);
    chk("rst_arid", arId, 0);
    chk("rst_cnt", outstandingReqCnt, 0);
    chk("rst_pfallowed", pfAllowed, 1);

    // Simultaneous demand and prefetch: demand first, prefetch AR three cycles later.
    tick();
    demValid = 1'b1; demAddr = 64'h1000; demId = 4'h5;
    pfValid = 1'b1; pfAddr = 64'h2000; arReady = 1'b1;
    settle();
    chk("t1_demready", demReady, 1);
    chk("t1_pfready_lost", pfReady, 0);
    tick();
    demValid = 1'b0;
    settle();
    chk("t1_arvalid_dem", arValid, 1);
    chk("t1_araddr_dem", arAddr, 64'h1000);
    chk("t1_arid_dem", arId, 5'h05);
    chk("t1_pfready_hold", pfReady, 0);
    tick();
    chk("t1_idle_gap", arValid, 0);
    chk("t1_cnt1", outstandingReqCnt, 1);
    chk("t1_pfready", pfReady, 1);
    tick();
    pfValid = 1'b0;
    settle();
    chk("t1_arvalid_pf", arValid, 1);
    chk("t1_arid_pf", arId, 5'h10);
    chk("t1_araddr_pf", arAddr, 64'h2000);
    tick();
    chk("t1_cnt2", outstandingReqCnt, 2);

    // Continuous demand stream starves the prefetch for exactly 8 lost grants.
    pfValid = 1'b1; pfAddr = 64'h3000; demValid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      demAddr = 64'h100 + 64'(i); demId = 4'(i);
      settle();
      chk("t2_demready", demReady, 1);
      chk("t2_pfready_starved", pfReady, 0);
      tick();
      chk("t2_arid", arId, {1'b0, 4'(i)});
      tick();
    end
    chk("t2_cnt10", outstandingReqCnt, 10);
    chk("t2_pf_forced", pfReady, 1);
    chk("t2_dem_blocked", demReady, 0);
    tick();
    chk("t2_arid_pf", arId, 5'h10);
    chk("t2_araddr_pf", arAddr, 64'h3000);
    tick();
    chk("t2_cnt11", outstandingReqCnt, 11);
    chk("t2_starve_cleared_dem", demReady, 1);
    chk("t2_starve_cleared_pf", pfReady, 0);

    // Demand AR held with arReady low for 5 cycles.
    do_reset();
    demValid = 1'b1; demAddr = 64'hABCD; demId = 4'hA; arReady = 1'b0;
    settle();
    chk("t3_demready", demReady, 1);
    tick();
    demValid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_arvalid_stable", arValid, 1);
      chk("t3_araddr_stable", arAddr, 64'hABCD);
      chk("t3_arid_stable", arId, 5'h0A);
      chk("t3_cnt0", outstandingReqCnt, 0);
      tick();
    end
    arReady = 1'b1;
    settle();
    chk("t3_arvalid_hs", arValid, 1);
    tick();
    chk("t3_arvalid_drop", arValid, 0);
    chk("t3_cnt1", outstandingReqCnt, 1);

    // Limit of 2 prefetches blocks a third one but not demand.
    do_reset();
    outstandingReqLimit = 7'd2; pfValid = 1'b1; pfAddr = 64'h4000;
    settle();
    chk("t4_pf1", pfReady, 1);
    tick(); tick();
    chk("t4_pf2", pfReady, 1);
    tick(); tick();
    chk("t4_cnt2", outstandingReqCnt, 2);
    chk("t4_pfallowed0", pfAllowed, 0);
    chk("t4_pf_blocked", pfReady, 0);
    tick();
    chk("t4_idle", arValid, 0);
    demValid = 1'b1; demAddr = 64'h5000; demId = 4'h3;
    settle();
    chk("t4_dem_granted", demReady, 1);
    chk("t4_pf_still_blocked", pfReady, 0);
    tick();
    demValid = 1'b0; pfValid = 1'b0;
    tick();
    chk("t4_cnt3", outstandingReqCnt, 3);

    // R routing and completion counting.
    rValid = 1'b1; rLast = 1'b1; rId = 5'h10; pfRReady = 1'b0; demRReady = 1'b1;
    settle();
    chk("t5_rready_pf_stall", rReady, 0);
    chk("t5_pfrvalid", pfRValid, 1);
    chk("t5_demrvalid0", demRValid, 0);
    tick();
    chk("t5_cnt_hold", outstandingReqCnt, 3);
    pfRReady = 1'b1;
    settle();
    chk("t5_rready_pf", rReady, 1);
    tick();
    chk("t5_cnt_dec", outstandingReqCnt, 2);
    rId = 5'h03; demRReady = 1'b0;
    settle();
    chk("t5_rready_dem_stall", rReady, 0);
    chk("t5_demrvalid", demRValid, 1);
    chk("t5_pfrvalid0", pfRValid, 0);
    demRReady = 1'b1; rLast = 1'b0;
    tick();
    chk("t5_cnt_not_last", outstandingReqCnt, 2);
    rLast = 1'b1;
    tick();
    rValid = 1'b0;
    settle();
    chk("t5_cnt_last", outstandingReqCnt, 1);
    chk("t5_pfallowed1", pfAllowed, 1);

    // Same-cycle AR handshake and R last leaves the count unchanged.
    demValid = 1'b1; demAddr = 64'h6000; demId = 4'h1;
    tick();
    demValid = 1'b0;
    rValid = 1'b1; rLast = 1'b1; rId = 5'h00; demRReady = 1'b1;
    settle();
    chk("t6_arvalid", arValid, 1);
    tick();
    rValid = 1'b0;
    settle();
    chk("t6_cnt_same", outstandingReqCnt, 1);
    chk("t6_arvalid_drop", arValid, 0);

    // Flush blocks prefetch grant but does not retract a held one; reset does.
    outstandingReqLimit = 7'd10; pfValid = 1'b1; pfAddr = 64'h7000; arReady = 1'b0;
    flushN = 1'b0;
    settle();
    chk("t6_flush_blocks", pfReady, 0);
    flushN = 1'b1;
    settle();
    chk("t6_pfready", pfReady, 1);
    tick();
    pfValid = 1'b0; flushN = 1'b0;
    tick();
    chk("t6_flush_keeps_ar", arValid, 1);
    chk("t6_flush_keeps_id", arId, 5'h10);
    reset = 1'b1;
    tick();
    chk("t6_rst_arvalid", arValid, 0);
    chk("t6_rst_cnt", outstandingReqCnt, 0);
    chk("t6_rst_arid", arId, 0);
    chk("t6_rst_araddr", arAddr, 0);
    reset = 1'b0; flushN = 1'b1;
    tick();
    chk("t6_idle_after_rst", arValid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
